// File: rtl/prng_pkg.sv
// Shared constants and types for the multi-channel xorshift masking PRNG.
//   PRNG_DEFAULT_SEED : replacement value for an all-zero seed channel (xor'd with k+1)
//   XS_SHL_A/B/C      : xorshift shift amounts (x^=x<<13; x^=x>>7; x^=x<<17)
//   prng_state_e      : control FSM states
package prng_pkg;

  localparam logic [63:0] PRNG_DEFAULT_SEED = 64'h9E3779B97F4A7C15;

  localparam int unsigned XS_SHL_A = 13;
  localparam int unsigned XS_SHR_B = 7;
  localparam int unsigned XS_SHL_C = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } prng_state_e;

endpackage

// File: rtl/prng_multi_xorshift.sv
// One combinational xorshift step on a RADIX-bit word, truncated to RADIX bits.
//   x   : current channel word
//   y_c : next channel word (nonzero whenever x is nonzero)
module prng_multi_xorshift
  import prng_pkg::*;
#(
  parameter int unsigned RADIX = 64
) (
  input  logic [RADIX-1:0] x,
  output logic [RADIX-1:0] y_c
);

  logic [RADIX-1:0] stage_a;
  logic [RADIX-1:0] stage_b;

  // Three shift/xor stages; shifts drop bits past RADIX.
  always_comb begin
    stage_a = x ^ (x << XS_SHL_A);
    stage_b = stage_a ^ (stage_a >> XS_SHR_B);
    y_c     = stage_b ^ (stage_b << XS_SHL_C);
  end

endmodule

// File: rtl/prng_multi.sv
// NUM_CH independent xorshift channels with seed intake, zero-seed protection
// and a reseed-interval counter, feeding masks to the masked datapath.
//   clock, rst  : rising-edge clock, asynchronous active-high reset
//   enable      : block enable; low forces IDLE and clears the channels
//   seed_valid/seed_ready/seed : seed intake, channel k at [k*RADIX +: RADIX]
//   rnd_valid/rnd_ready/rnd    : mask output, channel k at [k*RADIX +: RADIX]
//   reseed_req  : level, interval exhausted; cleared when a new seed loads
//   zero_seed   : one-cycle pulse after accepting a seed with an all-zero channel
module prng_multi
  import prng_pkg::*;
#(
  parameter int unsigned RADIX           = 64,
  parameter int unsigned NUM_CH          = 2,
  parameter int unsigned RESEED_INTERVAL = 1024,
  parameter int unsigned STRICT_RESEED   = 0
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    seed_valid,
  output logic                    seed_ready,
  input  logic [NUM_CH*RADIX-1:0] seed,
  output logic                    rnd_valid,
  input  logic                    rnd_ready,
  output logic [NUM_CH*RADIX-1:0] rnd,
  output logic                    reseed_req,
  output logic                    zero_seed
);

  localparam int unsigned W        = NUM_CH * RADIX;
  localparam bit          CNT_EN   = (RESEED_INTERVAL != 0);
  localparam bit          STRICT_ON = (STRICT_RESEED != 0);
  // Keep at least one bit so the disabled-counter build still elaborates.
  localparam int unsigned CNT_W    = CNT_EN ? $clog2(RESEED_INTERVAL + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RESEED_INTERVAL);

  // Elaboration-time parameter guards.
  if (!(RADIX == 32 || RADIX == 64)) begin : g_bad_radix
    $error("prng_multi: RADIX must be 32 or 64");
  end
  if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
    $error("prng_multi: NUM_CH must be in 1..16");
  end

  prng_state_e      state_q;
  prng_state_e      state_d;
  logic [W-1:0]     seed_buf_q;
  logic [CNT_W-1:0] count_q;
  logic [W-1:0]     san_c;
  logic             any_zero_c;
  logic [W-1:0]     step_c;
  logic             seed_acc_c;
  logic             rnd_xfer_c;

  assign seed_acc_c = seed_valid & seed_ready;
  assign rnd_xfer_c = rnd_valid & rnd_ready;

  // Replace each all-zero seed channel by the default seed tagged with k+1.
  always_comb begin
    san_c      = seed;
    any_zero_c = 1'b0;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      if (seed[k*RADIX +: RADIX] == '0) begin
        san_c[k*RADIX +: RADIX] = PRNG_DEFAULT_SEED[RADIX-1:0] ^ RADIX'(k + 1);
        any_zero_c              = 1'b1;
      end
    end
  end

  // One xorshift stepper per channel, fed from the live output word.
  for (genvar k = 0; k < int'(NUM_CH); k++) begin : g_ch
    prng_multi_xorshift #(
      .RADIX(RADIX)
    ) u_xs (
      .x  (rnd[k*RADIX +: RADIX]),
      .y_c(step_c[k*RADIX +: RADIX])
    );
  end

  // FSM state register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a seed accept in RUN abandons the pending step.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (seed_acc_c) state_d = LOAD;
        LOAD:    state_d = RUN;
        RUN:     if (seed_acc_c) state_d = LOAD;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs; rst gating keeps seed_ready low while reset is held.
  always_comb begin
    seed_ready = 1'b0;
    rnd_valid  = 1'b0;
    seed_ready = enable & ~rst & (state_q != LOAD);
    rnd_valid  = (state_q == RUN) & ~(STRICT_ON & reseed_req);
  end

  // Channel registers, interval counter and status flags.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rnd        <= '0;
      seed_buf_q <= '0;
      count_q    <= '0;
      reseed_req <= 1'b0;
      zero_seed  <= 1'b0;
    end else begin
      zero_seed <= seed_acc_c & any_zero_c;
      if (seed_acc_c) begin
        seed_buf_q <= san_c;
      end
      if (!enable) begin
        rnd        <= '0;
        count_q    <= '0;
        reseed_req <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: begin
            rnd        <= '0;
            count_q    <= '0;
            reseed_req <= 1'b0;
          end
          LOAD: begin
            rnd        <= seed_buf_q;
            count_q    <= '0;
            reseed_req <= 1'b0;
          end
          RUN: begin
            if (rnd_xfer_c && !seed_acc_c) begin
              rnd <= step_c;
              // Counter saturates at the interval; reseed_req stays up until reload.
              if (CNT_EN && (count_q != CNT_MAX)) begin
                count_q <= count_q + CNT_W'(1);
                if (count_q == (CNT_MAX - CNT_W'(1))) begin
                  reseed_req <= 1'b1;
                end
              end
            end
          end
          default: begin
            rnd <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prng_multi.sv
// Self-checking bench for prng_multi: a word-level reference model checked on
// every cycle, plus hand-computed literal expectations along the directed run.
module tb_prng_multi;

  localparam int unsigned RADIX  = 64;
  localparam int unsigned NCH    = 2;
  localparam int unsigned IV     = 4;
  localparam bit          STRICT = 1'b1;
  localparam int unsigned W      = RADIX * NCH;
  localparam logic [63:0] DEF    = 64'h9E3779B97F4A7C15;

  logic         clock = 1'b0;
  logic         rst;
  logic         enable;
  logic         seed_valid;
  logic         rnd_ready;
  logic [W-1:0] seed;
  logic         seed_ready, rnd_valid, reseed_req, zero_seed;
  logic [W-1:0] rnd;
  logic         b_seed_ready, b_rnd_valid, b_reseed_req, b_zero_seed;
  logic [W-1:0] b_rnd;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  prng_multi #(
    .RADIX(RADIX), .NUM_CH(NCH), .RESEED_INTERVAL(IV), .STRICT_RESEED(1)
  ) dut (
    .clock(clock), .rst(rst), .enable(enable),
    .seed_valid(seed_valid), .seed_ready(seed_ready), .seed(seed),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd(rnd),
    .reseed_req(reseed_req), .zero_seed(zero_seed)
  );

  // Interval-disabled instance on the same stimulus.
  prng_multi #(
    .RADIX(RADIX), .NUM_CH(NCH), .RESEED_INTERVAL(0), .STRICT_RESEED(0)
  ) dut_free (
    .clock(clock), .rst(rst), .enable(enable),
    .seed_valid(seed_valid), .seed_ready(b_seed_ready), .seed(seed),
    .rnd_valid(b_rnd_valid), .rnd_ready(rnd_ready), .rnd(b_rnd),
    .reseed_req(b_reseed_req), .zero_seed(b_zero_seed)
  );

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] xs(input logic [63:0] x);
    logic [63:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 7);
    v = v ^ (v << 17);
    return v;
  endfunction

  // Reference model: current output word, a seed waiting to be loaded,
  // whether words are flowing, and how many words this seed has produced.
  logic [W-1:0] m_rnd, m_buf;
  bit           m_run, m_pend, m_req, m_zero;
  int           m_cnt;

  task automatic model_step();
    bit           acc, anyz;
    logic [W-1:0] san;
    if (rst) begin
      m_rnd = '0; m_buf = '0; m_run = 0; m_pend = 0; m_req = 0; m_zero = 0; m_cnt = 0;
      return;
    end
    acc  = seed_valid && enable && !m_pend;
    san  = seed;
    anyz = 0;
    for (int k = 0; k < int'(NCH); k++) begin
      if (seed[k*RADIX +: RADIX] == 64'd0) begin
        anyz = 1;
        san[k*RADIX +: RADIX] = DEF ^ 64'(k + 1);
      end
    end
    m_zero = acc && anyz;
    if (!enable) begin
      m_rnd = '0; m_run = 0; m_pend = 0; m_req = 0; m_cnt = 0;
    end else if (m_pend) begin
      m_rnd = m_buf; m_cnt = 0; m_req = 0; m_pend = 0; m_run = 1;
    end else if (acc) begin
      m_buf = san; m_pend = 1; m_run = 0;
    end else if (m_run && rnd_ready && !(STRICT && m_req)) begin
      for (int k = 0; k < int'(NCH); k++)
        m_rnd[k*RADIX +: RADIX] = xs(m_rnd[k*RADIX +: RADIX]);
      if (m_cnt < int'(IV)) begin
        m_cnt++;
        if (m_cnt == int'(IV)) m_req = 1;
      end
    end
  endtask

  initial begin
    m_rnd = '0; m_buf = '0; m_run = 0; m_pend = 0; m_req = 0; m_zero = 0; m_cnt = 0;
    forever begin
      @(posedge clock or posedge rst);
      model_step();
    end
  end

  // Per-cycle comparison against the model, on the falling edge.
  initial begin
    forever begin
      @(negedge clock);
      check("m_rnd", rnd, m_rnd);
      check("m_rnd_valid", W'(rnd_valid), W'(m_run && !(STRICT && m_req)));
      check("m_seed_ready", W'(seed_ready), W'(enable && !rst && !m_pend));
      check("m_reseed_req", W'(reseed_req), W'(m_req));
      check("m_zero_seed", W'(zero_seed), W'(m_zero));
      check("free_reseed_req", W'(b_reseed_req), W'(0));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Present a seed and hold it until accepted (bounded wait).
  task automatic send_seed(input logic [W-1:0] v);
    bit ok;
    ok = 0;
    seed = v;
    seed_valid = 1;
    for (int i = 0; i < 20; i++) begin
      if (seed_ready) begin
        ok = 1;
        break;
      end
      tick();
    end
    check("seed_accept_wait", W'(ok), W'(1));
    tick();
    seed_valid = 0;
  endtask

  initial begin
    rst = 1; enable = 0; seed_valid = 0; rnd_ready = 0; seed = '0;
    tick(); tick();
    rst = 0; enable = 1;

    // T1: enabled but never seeded stays idle.
    repeat (6) tick();
    check("t1_rnd", rnd, '0);
    check("t1_valid", W'(rnd_valid), W'(0));
    check("t1_req", W'(reseed_req), W'(0));

    // T2: golden seed 1/2, first word at t+2 and then one step.
    rnd_ready = 1;
    send_seed({64'd2, 64'd1});
    check("t2_valid_t1", W'(rnd_valid), W'(0));
    tick();
    check("t2_valid_t2", W'(rnd_valid), W'(1));
    check("t2_word0", rnd, {64'd2, 64'd1});
    tick();
    check("t2_word1", rnd, {64'h81044082, 64'h40822041});

    // T4: five cycles of backpressure hold the word.
    rnd_ready = 0;
    repeat (5) tick();
    check("t4_hold", rnd, {64'h81044082, 64'h40822041});
    check("t4_valid", W'(rnd_valid), W'(1));

    // T5: three more transfers exhaust the interval of 4 and stall.
    rnd_ready = 1;
    repeat (3) tick();
    check("t5_req", W'(reseed_req), W'(1));
    check("t5_stall", W'(rnd_valid), W'(0));
    repeat (3) tick();
    check("t5_still_stalled", W'(rnd_valid), W'(0));

    // T3: zero channel 0 is sanitised; reseed clears the request.
    send_seed({64'd5, 64'd0});
    check("t3_zero_pulse", W'(zero_seed), W'(1));
    tick();
    check("t3_zero_once", W'(zero_seed), W'(0));
    check("t5_req_cleared", W'(reseed_req), W'(0));
    check("t3_word0", rnd, {64'd5, 64'h9E3779B97F4A7C14});

    // T6: seed accept and transfer in the same cycle.
    seed = {64'hA5, 64'hC3};
    seed_valid = 1;
    tick();
    seed_valid = 0;
    check("t6_load_valid", W'(rnd_valid), W'(0));
    tick();
    check("t6_new_seed", rnd, {64'hA5, 64'hC3});

    // T6: enable low mid-RUN.
    tick();
    enable = 0;
    tick();
    check("t6_dis_rnd", rnd, '0);
    check("t6_dis_valid", W'(rnd_valid), W'(0));
    enable = 1;
    repeat (2) tick();
    check("t6_dis_idle", W'(rnd_valid), W'(0));

    // T6: rst mid-RUN clears immediately and needs a fresh seed.
    send_seed({64'd7, 64'd9});
    repeat (2) tick();
    rst = 1;
    #1;
    check("t6_rst_rnd", rnd, '0);
    check("t6_rst_valid", W'(rnd_valid), W'(0));
    tick();
    rst = 0;
    repeat (3) tick();
    check("t6_rst_idle", W'(rnd_valid), W'(0));
    check("t6_rst_idle_rnd", rnd, '0);

    // Mixed traffic, checked by the per-cycle model.
    for (int i = 0; i < 200; i++) begin
      rnd_ready  = ($urandom_range(0, 3) != 0);
      seed_valid = ($urandom_range(0, 11) == 0);
      enable     = ($urandom_range(0, 49) != 0);
      seed = {$urandom(), $urandom(), $urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) seed[63:0] = 64'd0;
      if ($urandom_range(0, 5) == 0) seed[127:64] = 64'd0;
      tick();
    end
    seed_valid = 0;
    enable = 1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
